// File: rtl/alu_1bit_if.sv
// alu_1bit_if -- operand/result bundle for one alu_1bit slice.
// The master drives the operands and the enable. The slave (the slice)
// returns registered results.
// ovf_o exists only when ALU_1BIT_OVF_EN is defined.
//
// Enable semantics:
//   - en_i is a qualifier with no backpressure.
//   - On every rising clk edge with en_i=1 (and no reset), the slice samples
//     the operand signals.
//   - The result is visible on f_o/cout_o one cycle later.
//   - When en_i=0, the results hold their previous value.
interface alu_1bit_if;
  logic       en_i;
  logic       a_i;
  logic       b_i;
  logic       cin_i;
  logic [3:0] sel_i;
  logic       shr_in_i;
  logic       shl_in_i;
  logic       f_o;
  logic       cout_o;
`ifdef ALU_1BIT_OVF_EN
  logic       ovf_o;
`endif

  // Driver side: produces operands, consumes results.
  modport master (
    output en_i, a_i, b_i, cin_i, sel_i, shr_in_i, shl_in_i,
`ifdef ALU_1BIT_OVF_EN
    input  ovf_o,
`endif
    input  f_o, cout_o
  );

  // Slice side: consumes operands, produces registered results.
  modport slave (
    input  en_i, a_i, b_i, cin_i, sel_i, shr_in_i, shl_in_i,
`ifdef ALU_1BIT_OVF_EN
    output ovf_o,
`endif
    output f_o, cout_o
  );
endinterface

// File: rtl/alu_1bit.sv
// alu_1bit -- one bit slice of a ripple ALU with registered outputs.
//
// sel_i[3:2] selects the group:
//   00 arithmetic
//   01 logic
//   10 shift right
//   11 shift left
// sel_i[1:0] selects the operation within the arithmetic and logic groups.
//
// Optional feature: define ALU_1BIT_OVF_EN to add a registered overflow
// output (ovf_o) on the interface.
module alu_1bit (
  input  logic       clk_i,
  input  logic       rst_i,
  alu_1bit_if.slave  bus
);

  typedef enum logic [1:0] {
    GRP_ARITH = 2'b00,
    GRP_LOGIC = 2'b01,
    GRP_SHR   = 2'b10,
    GRP_SHL   = 2'b11
  } grp_e;

  grp_e grp;
  logic y_op;
  logic sum;
  logic carry;
  logic f_d;
  logic f_q;
  logic cout_d;
  logic cout_q;

  assign grp = grp_e'(bus.sel_i[3:2]);

  // Second adder operand: 0, B, ~B or 1, depending on the arithmetic op.
  always_comb begin
    y_op = 1'b0;
    case (bus.sel_i[1:0])
      2'b00:   y_op = 1'b0;
      2'b01:   y_op = bus.b_i;
      2'b10:   y_op = ~bus.b_i;
      default: y_op = 1'b1;
    endcase
  end

  // Full adder.
  // It is only routed to the outputs in the arithmetic group, so cin_i
  // never reaches f/cout otherwise.
  assign sum   = bus.a_i ^ y_op ^ bus.cin_i;
  assign carry = (bus.a_i & y_op) | (bus.a_i & bus.cin_i) | (y_op & bus.cin_i);

  // Next-state result selection per group.
  always_comb begin
    f_d    = 1'b0;
    cout_d = 1'b0;
    case (grp)
      GRP_ARITH: begin
        f_d    = sum;
        cout_d = carry;
      end
      GRP_LOGIC: begin
        cout_d = 1'b0;
        case (bus.sel_i[1:0])
          2'b00:   f_d = bus.a_i & bus.b_i;
          2'b01:   f_d = bus.a_i | bus.b_i;
          2'b10:   f_d = bus.a_i ^ bus.b_i;
          default: f_d = ~bus.a_i;
        endcase
      end
      GRP_SHR: begin
        // The bit from the upper neighbour moves in.
        // Our own bit leaves toward the LSB side.
        f_d    = bus.shr_in_i;
        cout_d = bus.a_i;
      end
      default: begin
        // The bit from the lower neighbour moves in.
        // Our own bit leaves toward the MSB side.
        f_d    = bus.shl_in_i;
        cout_d = bus.a_i;
      end
    endcase
  end

  // Result registers.
  // Reset wins over enable; when enable is low the registers hold.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      f_q    <= 1'b0;
      cout_q <= 1'b0;
    end else if (bus.en_i) begin
      f_q    <= f_d;
      cout_q <= cout_d;
    end
  end

  assign bus.f_o    = f_q;
  assign bus.cout_o = cout_q;

`ifdef ALU_1BIT_OVF_EN
  logic ovf_d;
  logic ovf_q;

  // Signed overflow of the MSB slice: carry into this bit differs from the
  // carry out of it. Only meaningful in the arithmetic group.
  assign ovf_d = (grp == GRP_ARITH) ? (bus.cin_i ^ carry) : 1'b0;

  // Overflow register, with the same reset/enable behaviour as f_q.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovf_q <= 1'b0;
    end else if (bus.en_i) begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.ovf_o = ovf_q;
`endif

endmodule

// File: tb/tb_alu_1bit.sv
// tb_alu_1bit -- directed, table-driven bench for alu_1bit.
// Also checks ovf_o when ALU_1BIT_OVF_EN is defined.
module tb_alu_1bit;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  alu_1bit_if bus ();

  alu_1bit dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Packed result: {f, cout, ovf}. ovf is compared only when present.
  localparam int W = 3;

  logic [W-1:0] exp_q[$];
  int pass_cnt;
  int total_cnt;

  typedef struct {
    string      name;
    logic       en;
    logic       a;
    logic       b;
    logic       cin;
    logic [3:0] sel;
    logic       shr;
    logic       shl;
    logic       ef;
    logic       ec;
    logic       eo;
  } vec_t;

  vec_t vecs[$];

  // ---------------- driver tasks ----------------
  // Drive at the negative edge so the values are stable at the next
  // rising edge.
  task automatic drive(input logic en, input logic a, input logic b,
                       input logic cin, input logic [3:0] sel,
                       input logic shr, input logic shl);
    @(negedge clk);
    bus.en_i     = en;
    bus.a_i      = a;
    bus.b_i      = b;
    bus.cin_i    = cin;
    bus.sel_i    = sel;
    bus.shr_in_i = shr;
    bus.shl_in_i = shl;
  endtask

  // ---------------- scoreboard ----------------
  // Wait for the capturing edge, then pop the expected value and compare
  // it #1 later.
  task automatic check(input string name);
    logic [W-1:0] exp;
    logic [W-1:0] act;
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    act[2] = bus.f_o;
    act[1] = bus.cout_o;
`ifdef ALU_1BIT_OVF_EN
    act[0] = bus.ovf_o;
`else
    act[0] = 1'b0;
    exp[0] = 1'b0;
`endif
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got f/cout/ovf=%b required %b", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    drive(v.en, v.a, v.b, v.cin, v.sel, v.shr, v.shl);
    exp_q.push_back({v.ef, v.ec, v.eo});
    check(v.name);
  endtask

  // ---------------- test ----------------
  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst          = 1'b1;
    bus.en_i     = 1'b1;
    bus.a_i      = 1'b1;
    bus.b_i      = 1'b1;
    bus.cin_i    = 1'b1;
    bus.sel_i    = 4'b0001;
    bus.shr_in_i = 1'b1;
    bus.shl_in_i = 1'b1;

    // Reset overrides en_i=1 with inputs that would otherwise give f=1.
    exp_q.push_back(3'b000);
    check("reset_state");
    exp_q.push_back(3'b000);
    check("reset_held");

    // Release reset. From here the vector table runs with en=1.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);
    rst = 1'b0;

    //          name            en a  b  cin sel     shr shl  f  c  ovf
    vecs.push_back('{"add0_c0",  1, 1, 0, 0, 4'b0000, 0, 1,  1, 0, 0});
    vecs.push_back('{"add0_c1",  1, 1, 0, 1, 4'b0000, 0, 1,  0, 1, 0});
    vecs.push_back('{"addb_c0",  1, 1, 0, 0, 4'b0001, 0, 1,  1, 0, 0});
    vecs.push_back('{"addb_c1",  1, 1, 0, 1, 4'b0001, 0, 1,  0, 1, 0});
    vecs.push_back('{"subb_c0",  1, 1, 0, 0, 4'b0010, 0, 1,  0, 1, 1});
    vecs.push_back('{"subb_c1",  1, 1, 0, 1, 4'b0010, 0, 1,  1, 1, 0});
    vecs.push_back('{"dec_c0",   1, 1, 0, 0, 4'b0011, 0, 1,  0, 1, 1});
    vecs.push_back('{"dec_c1",   1, 1, 0, 1, 4'b0011, 0, 1,  1, 1, 0});
    vecs.push_back('{"and_cx",   1, 1, 0, 1'bx, 4'b0100, 0, 1, 0, 0, 0});
    vecs.push_back('{"or_cx",    1, 1, 0, 1'bx, 4'b0101, 0, 1, 1, 0, 0});
    vecs.push_back('{"xor_cx",   1, 1, 0, 1'bx, 4'b0110, 0, 1, 1, 0, 0});
    vecs.push_back('{"not_cx",   1, 1, 0, 1'bx, 4'b0111, 0, 1, 0, 0, 0});
    vecs.push_back('{"and_a0b1", 1, 0, 1, 0, 4'b0100, 0, 1,  0, 0, 0});
    vecs.push_back('{"or_a0b1",  1, 0, 1, 1, 4'b0101, 0, 1,  1, 0, 0});
    vecs.push_back('{"xor_a0b1", 1, 0, 1, 0, 4'b0110, 0, 1,  1, 0, 0});
    vecs.push_back('{"not_a0",   1, 0, 1, 1, 4'b0111, 0, 1,  1, 0, 0});
    vecs.push_back('{"shr",      1, 1, 0, 1'bx, 4'b1000, 0, 1, 0, 1, 0});
    vecs.push_back('{"shl",      1, 1, 0, 1'bx, 4'b1100, 0, 1, 1, 1, 0});
    vecs.push_back('{"shr_sel11",1, 1, 0, 1'bx, 4'b1011, 0, 1, 0, 1, 0});
    vecs.push_back('{"shl_a0",   1, 0, 0, 1, 4'b1111, 1, 0,  0, 0, 0});
    vecs.push_back('{"shr_a0",   1, 0, 1, 0, 4'b1001, 1, 0,  1, 0, 0});
    vecs.push_back('{"ovf_addb", 1, 1, 0, 1, 4'b0001, 0, 0,  0, 1, 0});
    vecs.push_back('{"ovf_inc0", 1, 0, 0, 1, 4'b0000, 0, 0,  1, 0, 1});
    vecs.push_back('{"addb_a0b1",1, 0, 1, 1, 4'b0001, 0, 0,  0, 1, 0});

    foreach (vecs[i]) run_vec(vecs[i]);

    // Hold: load f=1/c=1/ovf=0, then drop en for 3 cycles while toggling
    // the inputs.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 4'b0001, 1'b0, 1'b0);
    exp_q.push_back(3'b110);
    check("hold_load");
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, k[0], ~k[0], k[1], 4'($urandom_range(0, 15)),
            ~k[0], k[0]);
      exp_q.push_back(3'b110);
      check($sformatf("hold_%0d", k));
    end

    // Reset with a result in flight: en=1 and inputs would give f=1.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'b0101, 1'b0, 1'b0);
    rst = 1'b1;
    exp_q.push_back(3'b000);
    check("mid_reset");

    // First edge after release: the new result appears one cycle later.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0);
    rst = 1'b0;
    exp_q.push_back(3'b011);
    check("post_reset_first");

    // After reset with en low, outputs stay at the reset values.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'b0101, 1'b0, 1'b0);
    rst = 1'b1;
    exp_q.push_back(3'b000);
    check("reset_again");
    drive(1'b0, 1'b1, 1'b1, 1'b1, 4'b0011, 1'b1, 1'b1);
    rst = 1'b0;
    exp_q.push_back(3'b000);
    check("reset_then_hold");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
